b_to_bcd_mod: RTL and testbench



---
 rtl/bcd_pkg.sv | 14 +
 rtl/b_to_bcd_mod_if.sv | 13 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/b_to_bcd_mod.sv | 66 ++++++
 tb/tb_b_to_bcd_mod.sv | 89 ++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared widths and FSM state type for the binary-to-BCD converter.
package bcd_pkg;
   localparam int BIN_W        = 16;
   localparam int DIGIT_W      = 4;
   localparam int NUM_DIGITS   = 4;
   localparam int SCRATCH_W    = 20;
   localparam int SHIFT_CYCLES = 16;

   typedef enum logic [1:0] {
      LOAD,
      SHIFT,
      UPDATE
   } state_t;
endpackage

// File: rtl/b_to_bcd_mod_if.sv
// Binary input and BCD digit outputs of the converter, grouped as one bundle.
interface b_to_bcd_mod_if;
   import bcd_pkg::*;

   logic [BIN_W-1:0]   y;
   logic [DIGIT_W-1:0] ones;
   logic [DIGIT_W-1:0] tens;
   logic [DIGIT_W-1:0] hundreds;
   logic [DIGIT_W-1:0] thousands;

   modport master (output y, input ones, tens, hundreds, thousands);
   modport slave  (input y, output ones, tens, hundreds, thousands);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);
   always_comb begin
      q = d;
      if (d >= DIGIT_W'(5)) q = d + DIGIT_W'(3);
   end
endmodule

// File: rtl/b_to_bcd_mod.sv
// Free-running 18-cycle shift-and-add-3 converter from 16-bit binary to four
// registered BCD digits; the ten-thousands digit is dropped.
module b_to_bcd_mod
   import bcd_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   b_to_bcd_mod_if.slave  bus
);
   state_t                 state;
   logic [BIN_W-1:0]       bin;
   logic [SCRATCH_W-1:0]   scratch;
   logic [SCRATCH_W-1:0]   adj;
   logic [3:0]             cnt;
   logic [DIGIT_W-1:0]     ones_q, tens_q, hundreds_q, thousands_q;

   // Nibble 4 never reaches 5 within 16 shifts, so it bypasses correction.
   assign adj[SCRATCH_W-1 -: DIGIT_W] = scratch[SCRATCH_W-1 -: DIGIT_W];

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (scratch[i*DIGIT_W +: DIGIT_W]),
         .q (adj[i*DIGIT_W +: DIGIT_W])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD;
         bin         <= '0;
         scratch     <= '0;
         cnt         <= '0;
         ones_q      <= '0;
         tens_q      <= '0;
         hundreds_q  <= '0;
         thousands_q <= '0;
      end else begin
         case (state)
            LOAD: begin
               bin     <= bus.y;
               scratch <= '0;
               cnt     <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               {scratch, bin} <= {adj, bin} << 1;
               cnt            <= cnt + 4'd1;
               if (cnt == 4'(SHIFT_CYCLES - 1)) state <= UPDATE;
            end
            UPDATE: begin
               ones_q      <= scratch[0*DIGIT_W +: DIGIT_W];
               tens_q      <= scratch[1*DIGIT_W +: DIGIT_W];
               hundreds_q  <= scratch[2*DIGIT_W +: DIGIT_W];
               thousands_q <= scratch[3*DIGIT_W +: DIGIT_W];
               state       <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign bus.ones      = ones_q;
   assign bus.tens      = tens_q;
   assign bus.hundreds  = hundreds_q;
   assign bus.thousands = thousands_q;
endmodule

// File: tb/tb_b_to_bcd_mod.sv
// Directed bench for b_to_bcd_mod: reset, boundaries, overflow, mid-run y change and reset.
module tb_b_to_bcd_mod;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   b_to_bcd_mod_if bus ();

   b_to_bcd_mod dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] exp);
      logic [15:0] obs;
      obs = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Call right after an UPDATE edge: next edge is LOAD, result lands 18 edges later.
   task automatic convert(input string tag, input logic [15:0] val, input logic [15:0] exp);
      bus.y = val;
      edges(18);
      check(tag, exp);
   endtask

   initial begin
      reset = 1'b1;
      bus.y = 16'd1234;
      edges(1);
      check("reset_edge1", 16'h0000);
      edges(1);
      check("reset_edge2", 16'h0000);
      reset = 1'b0;
      edges(17);
      check("hold_before_first", 16'h0000);
      edges(1);
      check("first_1234", 16'h1234);

      convert("small_20", 16'd20,    16'h0020);
      convert("zero",     16'd0,     16'h0000);
      convert("nine",     16'd9,     16'h0009);
      convert("ten",      16'd10,    16'h0010);
      convert("max_4dig", 16'd9999,  16'h9999);
      convert("ovf_10000",16'd10000, 16'h0000);
      convert("ovf_65535",16'd65535, 16'h5535);

      // y changes the cycle after it is sampled; in-flight result must be unaffected
      bus.y = 16'd4321;
      edges(1);
      bus.y = 16'd7;
      edges(16);
      check("hold_mid_change", 16'h5535);
      edges(1);
      check("mid_change_4321", 16'h4321);
      edges(18);
      check("mid_change_7", 16'h0007);

      // abort after 7 completed shifts; reset is seen on the 8th shift edge
      bus.y = 16'd5678;
      edges(8);
      reset = 1'b1;
      edges(1);
      check("mid_reset_clear", 16'h0000);
      reset = 1'b0;
      edges(17);
      check("mid_reset_hold", 16'h0000);
      edges(1);
      check("after_reset_5678", 16'h5678);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
